ld_st_ctrl: RTL
===============

LD_ST_CTRL -- requirements
Module: ld_st_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of the memory byte address; legal values 16..32.
REQ-002 Parameter TIMEOUT_W, default 8, width of the timeout counter; timeout limit is 2**TIMEOUT_W-1 cycles.
REQ-003 clk_i  in  1  single clock; all state on the rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  in  1  pipeline presents a load/store request.
REQ-006 req_ready_o  out  1  block can accept a request.
REQ-007 load_en_i  in  1  1 = load, 0 = store.
REQ-008 funct3_i  in  3  RV32I width/sign code.
REQ-009 offset_i  in  12  signed immediate.
REQ-010 rs1_data_i  in  32  base address.
REQ-011 rs2_data_i  in  32  store data.
REQ-012 rd_addr_i  in  5  load destination register.
REQ-013 mem_req_o / mem_we_o  out  1 / 1  memory request, write enable.
REQ-014 mem_addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 0.
REQ-015 mem_be_o / mem_wdata_o  out  4 / 32  byte enables, write data.
REQ-016 mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1 / 1 / 32  grant, read-data valid, read data.
REQ-017 rsp_valid_o / rsp_rdata_o / rsp_rd_addr_o / rsp_err_o  out  1 / 32 / 5 / 2  completion pulse, load result, destination, error code (00 ok, 01 misaligned/illegal, 10 timeout).
REQ-018 busy_o  out  1  high in every state except IDLE.

Function
REQ-019 Effective address SHALL be rs1_data_i + sign-extended offset_i, truncated to ADDR_W bits, and registered at acceptance together with funct3, load_en, rs2 and rd.
REQ-020 Acceptance SHALL occur when req_valid_i && req_ready_o; req_ready_o SHALL be 1 only in IDLE.
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, RSP.
REQ-022 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; all other codes SHALL be treated as illegal.
REQ-023 Illegal code, halfword with addr[0]=1, or word with addr[1:0]!=0 SHALL go IDLE->RSP with no mem_req_o, err=01, rdata=0.
REQ-024 Legal accepted request SHALL go IDLE->REQ; mem_req_o SHALL be held high with stable addr/we/be/wdata until mem_gnt_i.
REQ-025 On grant: a store SHALL go REQ->RSP; a load SHALL go REQ->WAIT.
REQ-026 mem_rvalid_i SHALL be sampled only in WAIT; in WAIT with rvalid the block SHALL capture extracted data and go WAIT->RSP.
REQ-027 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads use the same mask.
REQ-028 Store data SHALL be replicated: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
REQ-029 Load data SHALL be selected by the latched addr[1:0], sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-030 RSP SHALL last exactly one cycle with rsp_valid_o=1, then return to IDLE; rsp_rd_addr_o = latched rd for loads, 0 for stores; rsp_rdata_o = 0 for stores.
REQ-031 The timeout counter SHALL clear on acceptance and increment every cycle in REQ or WAIT; at the limit the block SHALL go to RSP with err=10, rdata=0, and mem_req_o dropped.
REQ-032 When rvalid and timeout coincide in WAIT, rvalid SHALL win (err=00).
REQ-033 rsp_* outputs SHALL be 0 whenever rsp_valid_o is 0.
REQ-034 Best-case load latency: accept cycle N, mem_req_o cycle N+1 with gnt, rvalid cycle N+2, rsp_valid_o cycle N+3.

Reset
REQ-035 Asserting rst_n_i low SHALL immediately force IDLE, clear all registers, and drive every output to 0 except req_ready_o, which SHALL be 1 once in IDLE; in-flight transactions SHALL be abandoned without response.
REQ-036 After reset deassertion, the first request SHALL be accepted on the first rising edge at which req_valid_i=1.

Verification
REQ-037 LW: rs1=0x1000, offset=0x004, gnt immediate, rdata=0xDEADBEEF next cycle -> mem_addr=0x1004, be=1111, rsp_rdata=0xDEADBEEF at cycle N+3.
REQ-038 LB/LBU: addr=0x1003, rdata=0x80123456 -> LB yields 0xFFFFFF80; LBU yields 0x00000080; be=1000.
REQ-039 SH: rs1=0x2000, offset=0xFFE (-2), rs2=0x0000ABCD -> mem_addr=0x1FFC, be=1100, wdata=0xABCDABCD, we=1, rsp_rd_addr=0.
REQ-040 LW at 0x1002, or funct3=011 -> no mem_req_o, rsp_valid one cycle after acceptance with err=01.
REQ-041 Load with gnt held low for 255 cycles (TIMEOUT_W=8) -> err=10, mem_req_o low, back in IDLE, next request accepted.
REQ-042 rst_n_i pulsed low while in WAIT -> all outputs 0 asynchronously; a later rvalid produces no response.

Source files
------------

// File: rtl/ld_st_ctrl.sv
// ld_st_ctrl: load/store unit front end for an RV32I-style pipeline.
//
// Accepts one load/store request at a time from the pipeline, computes and
// checks the effective address, drives a simple request/grant memory port,
// waits for read data on loads, and emits a single-cycle completion pulse.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   req_valid_i/req_ready_o pipeline request handshake (ready only when idle)
//   load_en_i               1 = load, 0 = store
//   funct3_i                RV32I width/sign code
//   offset_i                12-bit signed immediate
//   rs1_data_i, rs2_data_i  base address, store data
//   rd_addr_i               load destination register
//   mem_req_o, mem_we_o     memory request, write enable
//   mem_addr_o              word-aligned byte address
//   mem_be_o, mem_wdata_o   byte enables, lane-replicated write data
//   mem_gnt_i               memory accepted the request
//   mem_rvalid_i/rdata_i    read data return
//   rsp_valid_o             one-cycle completion pulse
//   rsp_rdata_o             extracted, extended load result (0 for stores)
//   rsp_rd_addr_o           destination register (0 for stores)
//   rsp_err_o               00 ok, 01 misaligned/illegal, 10 timeout
//   busy_o                  high whenever the block is not idle
module ld_st_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // Pipeline request
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              load_en_i,
  input  logic [2:0]        funct3_i,
  input  logic [11:0]       offset_i,
  input  logic [31:0]       rs1_data_i,
  input  logic [31:0]       rs2_data_i,
  input  logic [4:0]        rd_addr_i,
  // Memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  // Completion
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [4:0]        rsp_rd_addr_o,
  output logic [1:0]        rsp_err_o,
  output logic              busy_o
);

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrAlign   = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  // Counter saturates at the limit; the request is abandoned on the cycle in
  // which the limit would be reached without progress.
  localparam logic [TIMEOUT_W-1:0] TmoLimit = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] TmoLast  = TmoLimit - 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StRsp
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  load_q, load_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic [TIMEOUT_W-1:0]  tmo_q, tmo_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            err_q, err_d;

  // ---------------------------------------------------------------------------
  // Effective address and request legality (evaluated on the incoming request)
  // ---------------------------------------------------------------------------
  logic [31:0]       ea_full;
  logic [ADDR_W-1:0] ea;
  logic              code_legal;
  logic              misaligned;

  assign ea_full = rs1_data_i + {{20{offset_i[11]}}, offset_i};
  assign ea      = ea_full[ADDR_W-1:0];

  always_comb begin
    code_legal = 1'b0;
    if (load_en_i) begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: code_legal = 1'b1;
        default:                                code_legal = 1'b0;
      endcase
    end else begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010: code_legal = 1'b1;
        default:                code_legal = 1'b0;
      endcase
    end

    // funct3[1:0] encodes the access size for every legal code
    case (funct3_i[1:0])
      2'b01:   misaligned = ea[0];
      2'b10:   misaligned = |ea[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte lanes for the latched request
  // ---------------------------------------------------------------------------
  logic [3:0]  be_lat;
  logic [31:0] wdata_rep;

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be_lat    = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_lat    = 4'b0011 << addr_q[1:0];
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be_lat    = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data extraction from the returned word
  // ---------------------------------------------------------------------------
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   rd_byte = mem_rdata_i[7:0];
      2'b01:   rd_byte = mem_rdata_i[15:8];
      2'b10:   rd_byte = mem_rdata_i[23:16];
      default: rd_byte = mem_rdata_i[31:24];
    endcase
    rd_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    case (funct3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = mem_rdata_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and datapath updates
  // ---------------------------------------------------------------------------
  logic                 tmo_expired;
  logic [TIMEOUT_W-1:0] tmo_inc;

  assign tmo_expired = (tmo_q >= TmoLast);
  assign tmo_inc     = (tmo_q == TmoLimit) ? tmo_q : tmo_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    load_d   = load_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    tmo_d    = tmo_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d   = ea;
          funct3_d = funct3_i;
          load_d   = load_en_i;
          wdata_d  = rs2_data_i;
          rd_d     = rd_addr_i;
          tmo_d    = '0;
          rdata_d  = '0;
          if (!code_legal || misaligned) begin
            // Never touches memory; report straight away
            err_d   = ErrAlign;
            state_d = StRsp;
          end else begin
            err_d   = ErrOk;
            state_d = StReq;
          end
        end
      end

      StReq: begin
        tmo_d = tmo_inc;
        if (mem_gnt_i) begin
          state_d = load_q ? StWait : StRsp;
        end else if (tmo_expired) begin
          err_d   = ErrTimeout;
          state_d = StRsp;
        end
      end

      StWait: begin
        tmo_d = tmo_inc;
        // Read data arriving on the timeout cycle still completes normally
        if (mem_rvalid_i) begin
          rdata_d = load_data;
          state_d = StRsp;
        end else if (tmo_expired) begin
          err_d   = ErrTimeout;
          state_d = StRsp;
        end
      end

      StRsp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= '0;
      load_q   <= 1'b0;
      wdata_q  <= '0;
      rd_q     <= '0;
      tmo_q    <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      load_q   <= load_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      tmo_q    <= tmo_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so reset clears them at once
  // ---------------------------------------------------------------------------
  logic in_req;
  logic in_rsp;

  assign in_req = (state_q == StReq);
  assign in_rsp = (state_q == StRsp);

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);

  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & ~load_q;
  assign mem_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be_o    = in_req ? be_lat : 4'b0000;
  assign mem_wdata_o = (in_req && !load_q) ? wdata_rep : '0;

  assign rsp_valid_o   = in_rsp;
  assign rsp_rdata_o   = (in_rsp && load_q) ? rdata_q : '0;
  assign rsp_rd_addr_o = (in_rsp && load_q) ? rd_q : '0;
  assign rsp_err_o     = in_rsp ? err_q : ErrOk;

endmodule
